// File: rtl/uart_mmio_bridge_pkg.sv
// Shared definitions for the memory-mapped UART window: register select
// encodings, byte width and the status-word packing helper.
package uart_mmio_bridge_pkg;

    typedef enum logic [1:0] {
        UART_TXSTAT = 2'd0,
        UART_RXSTAT = 2'd1,
        UART_TXDATA = 2'd2,
        UART_RXDATA = 2'd3
    } uart_sel_e;

    localparam int UART_BYTE_W = 8;
    localparam int UART_WORD_W = 32;

    // Single-bit status flag placed in bit 0 of a load word.
    function automatic logic [UART_WORD_W-1:0] status_word(input logic flag);
        return {31'b0, flag};
    endfunction

endpackage

// File: rtl/uart_mmio_bridge_byte_fifo.sv
// Byte queue with registered storage; the head is read straight from storage.
// Pushes when full and pops when empty are ignored.
module byte_fifo
    import uart_mmio_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_BYTE_W
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come from the start-of-cycle count, so a pop never frees room for a same-cycle push.
    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge Clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped UART window: status/data register decode, registered load data,
// TX and RX byte queues between the CPU and the serial transmitter/receiver.
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   REUART,
    input  logic                   WEUART,
    input  logic [1:0]             UARTsel,
    input  logic [UART_WORD_W-1:0] WriteData,
    output logic [UART_WORD_W-1:0] ReadData,
    output logic [UART_BYTE_W-1:0] UARTTxData,
    output logic                   UARTTxValid,
    input  logic                   UARTTxReady,
    input  logic [UART_BYTE_W-1:0] UARTRxData,
    input  logic                   UARTRxValid,
    output logic                   UARTRxReady,
    output logic                   TxOverflow,
    output logic                   RxOverflow
);

    uart_sel_e              sel_s;
    logic                   tx_push_s;
    logic                   tx_pop_s;
    logic                   tx_full_s;
    logic                   tx_empty_s;
    logic [$clog2(TX_DEPTH):0] tx_count_s;
    logic                   rx_pop_s;
    logic                   rx_full_s;
    logic                   rx_empty_s;
    logic [UART_BYTE_W-1:0] rx_head_s;
    logic [$clog2(RX_DEPTH):0] rx_count_s;
    logic [UART_WORD_W-1:0] read_data_r;
    logic                   tx_ovf_r;
    logic                   rx_ovf_r;
    logic                   unused_s;

    assign sel_s     = uart_sel_e'(UARTsel);
    assign tx_push_s = WEUART & (sel_s == UART_TXDATA);
    assign tx_pop_s  = UARTTxValid & UARTTxReady;
    assign rx_pop_s  = REUART & (sel_s == UART_RXDATA);

    // Handshakes are forced low during reset, before the queue state is known.
    assign UARTTxValid = ~tx_empty_s & ~Reset;
    assign UARTRxReady = ~rx_full_s & ~Reset;
    assign ReadData    = read_data_r;
    assign TxOverflow  = tx_ovf_r;
    assign RxOverflow  = rx_ovf_r;
    assign unused_s    = ^{WriteData[UART_WORD_W-1:UART_BYTE_W], tx_count_s, rx_count_s};

    byte_fifo #(.DEPTH(TX_DEPTH), .WIDTH(UART_BYTE_W)) u_tx_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (tx_push_s),
        .din   (WriteData[UART_BYTE_W-1:0]),
        .pop   (tx_pop_s),
        .dout  (UARTTxData),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    byte_fifo #(.DEPTH(RX_DEPTH), .WIDTH(UART_BYTE_W)) u_rx_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (UARTRxValid),
        .din   (UARTRxData),
        .pop   (rx_pop_s),
        .dout  (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    // Load data register: one-cycle latency, holds when no load is issued.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            read_data_r <= {UART_WORD_W{1'b0}};
        end else if (REUART) begin
            case (sel_s)
                UART_TXSTAT: read_data_r <= status_word(~tx_full_s);
                UART_RXSTAT: read_data_r <= status_word(~rx_empty_s);
                UART_TXDATA: read_data_r <= {UART_WORD_W{1'b0}};
                UART_RXDATA: read_data_r <= rx_empty_s ? {UART_WORD_W{1'b0}}
                                                       : {24'b0, rx_head_s};
                default:     read_data_r <= {UART_WORD_W{1'b0}};
            endcase
        end else begin
            read_data_r <= read_data_r;
        end
    end

    // Sticky overflow flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tx_ovf_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            if (tx_push_s & tx_full_s) begin
                tx_ovf_r <= 1'b1;
            end else if (WEUART & (sel_s == UART_TXSTAT)) begin
                tx_ovf_r <= 1'b0;
            end
            if (UARTRxValid & rx_full_s) begin
                rx_ovf_r <= 1'b1;
            end else if (WEUART & (sel_s == UART_RXSTAT)) begin
                rx_ovf_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: hand-derived vector table, directed
// corner-case sequences and randomized traffic against a queue-based reference model.
module tb_uart_mmio_bridge;

    logic        Clock;
    logic        Reset;
    logic        REUART;
    logic        WEUART;
    logic [1:0]  UARTsel;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  UARTTxData;
    logic        UARTTxValid;
    logic        UARTTxReady;
    logic [7:0]  UARTRxData;
    logic        UARTRxValid;
    logic        UARTRxReady;
    logic        TxOverflow;
    logic        RxOverflow;

    int total;
    int bad;

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic [31:0] m_rd;
    logic        m_txovf;
    logic        m_rxovf;

    uart_mmio_bridge #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .REUART      (REUART),
        .WEUART      (WEUART),
        .UARTsel     (UARTsel),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .UARTTxData  (UARTTxData),
        .UARTTxValid (UARTTxValid),
        .UARTTxReady (UARTTxReady),
        .UARTRxData  (UARTRxData),
        .UARTRxValid (UARTRxValid),
        .UARTRxReady (UARTRxReady),
        .TxOverflow  (TxOverflow),
        .RxOverflow  (RxOverflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the rules of the UART window to the inputs present at this edge.
    task automatic model_edge();
        bit tx_full, tx_empty, rx_full, rx_empty, tx_pop, tx_push, rx_pop, rx_push;
        tx_full  = (txq.size() == 4);
        tx_empty = (txq.size() == 0);
        rx_full  = (rxq.size() == 4);
        rx_empty = (rxq.size() == 0);
        if (Reset) begin
            txq.delete();
            rxq.delete();
            m_rd    = 32'h0;
            m_txovf = 1'b0;
            m_rxovf = 1'b0;
            return;
        end
        if (REUART) begin
            case (UARTsel)
                2'd0: m_rd = {31'b0, !tx_full};
                2'd1: m_rd = {31'b0, !rx_empty};
                2'd2: m_rd = 32'h0;
                default: m_rd = rx_empty ? 32'h0 : {24'h0, rxq[0]};
            endcase
        end
        rx_pop  = REUART && UARTsel == 2'd3 && !rx_empty;
        tx_pop  = !tx_empty && UARTTxReady;
        tx_push = WEUART && UARTsel == 2'd2 && !tx_full;
        rx_push = UARTRxValid && !rx_full;
        if (WEUART && UARTsel == 2'd0) m_txovf = 1'b0;
        if (WEUART && UARTsel == 2'd1) m_rxovf = 1'b0;
        if (WEUART && UARTsel == 2'd2 && tx_full) m_txovf = 1'b1;
        if (UARTRxValid && rx_full) m_rxovf = 1'b1;
        if (tx_pop) void'(txq.pop_front());
        if (rx_pop) void'(rxq.pop_front());
        if (tx_push) txq.push_back(WriteData[7:0]);
        if (rx_push) rxq.push_back(UARTRxData);
    endtask

    task automatic compare_model();
        bit exp_txv;
        exp_txv = !Reset && (txq.size() > 0);
        check("readdata", ReadData, m_rd);
        check("txvalid", {31'b0, UARTTxValid}, {31'b0, exp_txv});
        if (exp_txv) check("txdata", {24'h0, UARTTxData}, {24'h0, txq[0]});
        check("rxready", {31'b0, UARTRxReady}, {31'b0, (!Reset && rxq.size() < 4)});
        check("txoverflow", {31'b0, TxOverflow}, {31'b0, m_txovf});
        check("rxoverflow", {31'b0, RxOverflow}, {31'b0, m_rxovf});
    endtask

    task automatic step(input bit rst, input bit re, input bit we, input bit [1:0] sel,
                        input bit [7:0] wd, input bit txr, input bit [7:0] rxd, input bit rxv);
        Reset       = rst;
        REUART      = re;
        WEUART      = we;
        UARTsel     = sel;
        WriteData   = {24'hA5A5A5, wd};
        UARTTxReady = txr;
        UARTRxData  = rxd;
        UARTRxValid = rxv;
        @(posedge Clock);
        model_edge();
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          rst;
        bit          re;
        bit          we;
        bit [1:0]    sel;
        bit [7:0]    wd;
        bit          txr;
        logic [31:0] e_rd;
        bit          e_txv;
        bit [7:0]    e_txd;
        bit          e_txovf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        total = 0;
        bad   = 0;
        m_rd = 32'h0; m_txovf = 1'b0; m_rxovf = 1'b0;
        Reset = 1'b1; REUART = 1'b0; WEUART = 1'b0; UARTsel = 2'd0;
        WriteData = 32'h0; UARTTxReady = 1'b0; UARTRxData = 8'h0; UARTRxValid = 1'b0;

        // Reset state, status reads, TX fill/overflow and drain in order
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0000_0001, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h41, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h42, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h43, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h44, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h45, 1'b0, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h0000_0000, 1'b1, 8'h42, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h0000_0000, 1'b1, 8'h43, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h0000_0000, 1'b1, 8'h44, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 32'h0000_0000, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].re, vecs[i].we, vecs[i].sel, vecs[i].wd, vecs[i].txr, 8'h00, 1'b0);
            check($sformatf("vec%0d_rd", i), ReadData, vecs[i].e_rd);
            check($sformatf("vec%0d_txv", i), {31'b0, UARTTxValid}, {31'b0, vecs[i].e_txv});
            if (vecs[i].e_txv) check($sformatf("vec%0d_txd", i), {24'h0, UARTTxData}, {24'h0, vecs[i].e_txd});
            check($sformatf("vec%0d_txovf", i), {31'b0, TxOverflow}, {31'b0, vecs[i].e_txovf});
        end

        // Single RX byte, then read past empty
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h5A, 1'b1);
        step(1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_stat_one", ReadData, 32'h1);
        step(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_data_5a", ReadData, 32'h5A);
        step(1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_stat_zero", ReadData, 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_underflow", ReadData, 32'h0);

        // Fill RX, overflow, drain, clear flag
        for (int b = 1; b <= 4; b++) step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'(b), 1'b1);
        check("rx_full_ready", {31'b0, UARTRxReady}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h05, 1'b1);
        check("rx_ovf_set", {31'b0, RxOverflow}, 32'h1);
        for (int b = 1; b <= 4; b++) begin
            step(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
            check("rx_drain", ReadData, 32'(b));
        end
        step(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_drain_empty", ReadData, 32'h0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rx_ovf_clear", {31'b0, RxOverflow}, 32'h0);

        // Simultaneous TX push and pop keeps order
        step(1'b0, 1'b0, 1'b1, 2'd2, 8'hAA, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 8'hBB, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 8'h77, 1'b1, 8'h00, 1'b0);
        check("tx_pp_head", {24'h0, UARTTxData}, 32'hBB);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("tx_pp_last", {24'h0, UARTTxData}, 32'h77);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("tx_pp_empty", {31'b0, UARTTxValid}, 32'h0);

        // Reset discards queued TX bytes
        for (int b = 0; b < 3; b++) step(1'b0, 1'b0, 1'b1, 2'd2, 8'h90 + 8'(b), 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("rst_txv", {31'b0, UARTTxValid}, 32'h0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0);
        check("rst_txstat", ReadData, 32'h1);
        check("rst_txv_after", {31'b0, UARTTxValid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00, 1'b0);
            check("rst_no_stale", {31'b0, UARTTxValid}, 32'h0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
                 8'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
